// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
// Optional feature macro: UART_LOADER_CKSUM_EN (see uart_iccm_loader.sv).
package uart_loader_pkg;

    // Serial receiver states
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

    // Loader states
    typedef enum logic [1:0] {
        LD_WAIT_EN,
        LD_LOAD,
        LD_WRITE,
        LD_DONE
    } ld_state_e;

    // Word that terminates the program image
    localparam logic [31:0] EOP_WORD_DEFAULT = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_iccm_loader_rx.sv
// uart_rx_core: 8N1 UART receiver with 2-flop input synchronizer.
// Emits a one-cycle byte_valid_o when the stop bit samples high and a
// one-cycle frame_err_o pulse when it samples low (byte dropped).
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 347
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_data_o,
    output logic       frame_err_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_meta_q;
    logic             rx_sync_q;
    logic             rx_prev_q;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic             byte_valid_q;
    logic             frame_err_q;

    // Synchronize the asynchronous line and keep one extra delayed copy for edge detection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Receive FSM: start-bit qualification at half bit, then sample at bit centres
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= RX_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_sync_q) begin
                        state_q <= RX_START;
                        cnt_q   <= '0;
                    end
                end
                RX_START: begin
                    if (cnt_q == HALF_M1) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        // A line that is already high again was only a glitch
                        state_q   <= rx_sync_q ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        shift_q <= {rx_sync_q, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= RX_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt_q == FULL_M1) begin
                        cnt_q   <= '0;
                        state_q <= RX_IDLE;
                        if (rx_sync_q) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= RX_IDLE;
            endcase
        end
    end

    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = shift_q;
    assign frame_err_o  = frame_err_q;

endmodule

// File: rtl/uart_iccm_loader.sv
// uart_iccm_loader: receives a little-endian word stream over UART and
// writes it into instruction memory, then releases the core from reset.
// Optional feature macro: UART_LOADER_CKSUM_EN -- when defined, the word
// after the end-of-program marker is a modulo-2^32 checksum of all written
// words; on mismatch the core is held in reset and cksum_err_o is set.
module uart_iccm_loader
    import uart_loader_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 347,
    parameter int          ADDR_W       = 13,
    parameter logic [31:0] EOP_WORD     = EOP_WORD_DEFAULT
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              en_i,
    input  logic              rx_i,
    output logic              prog_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_ack_i,
    output logic              core_rst_o,
    output logic              done_o,
    output logic              frame_err_o,
    output logic              cksum_err_o
);

    logic       rx_byte_vld;
    logic [7:0] rx_byte;
    logic       rx_ferr;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk_i       (wb_clk_i),
        .rst_i       (wb_rst_i),
        .rx_i        (rx_i),
        .byte_valid_o(rx_byte_vld),
        .byte_data_o (rx_byte),
        .frame_err_o (rx_ferr)
    );

    ld_state_e         state_q;
    // Accumulator doubles as the one-word skid buffer while a write is pending
    logic [31:0]       acc_q;
    logic [1:0]        byte_cnt_q;
    logic              word_vld_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic              prog_ready_q;
    logic              core_rst_q;
    logic              done_q;
    logic              frame_err_q;
`ifdef UART_LOADER_CKSUM_EN
    logic [31:0]       cksum_q;
    logic              eop_seen_q;
    logic              cksum_err_q;
`endif

    // Loader FSM: word assembly, memory write handshake, completion and abort
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= LD_WAIT_EN;
            acc_q        <= '0;
            byte_cnt_q   <= '0;
            word_vld_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            prog_ready_q <= 1'b0;
            core_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            frame_err_q  <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
            cksum_q      <= '0;
            eop_seen_q   <= 1'b0;
            cksum_err_q  <= 1'b0;
`endif
        end else begin
            if (rx_ferr) begin
                frame_err_q <= 1'b1;
            end
            case (state_q)
                LD_WAIT_EN: begin
                    if (en_i) begin
                        state_q      <= LD_LOAD;
                        prog_ready_q <= 1'b1;
                    end
                end
                LD_LOAD, LD_WRITE: begin
                    if (!en_i) begin
                        // Abort: drop the pending write and any partial word
                        state_q      <= LD_WAIT_EN;
                        prog_ready_q <= 1'b0;
                        we_q         <= 1'b0;
                        addr_q       <= '0;
                        acc_q        <= '0;
                        byte_cnt_q   <= '0;
                        word_vld_q   <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
                        cksum_q      <= '0;
                        eop_seen_q   <= 1'b0;
`endif
                    end else begin
                        // Byte intake; a byte with the skid already full is an overflow
                        if (rx_byte_vld) begin
                            if (word_vld_q && (state_q == LD_WRITE)) begin
                                frame_err_q <= 1'b1;
                            end else begin
                                acc_q      <= {rx_byte, acc_q[31:8]};
                                byte_cnt_q <= byte_cnt_q + 2'd1;
                                if (byte_cnt_q == 2'd3) begin
                                    word_vld_q <= 1'b1;
                                end
                            end
                        end
                        if (state_q == LD_LOAD) begin
                            if (word_vld_q) begin
                                word_vld_q <= 1'b0;
`ifdef UART_LOADER_CKSUM_EN
                                if (eop_seen_q) begin
                                    state_q      <= LD_DONE;
                                    prog_ready_q <= 1'b0;
                                    done_q       <= 1'b1;
                                    cksum_err_q  <= (acc_q != cksum_q);
                                    core_rst_q   <= (acc_q != cksum_q);
                                end else if (acc_q == EOP_WORD) begin
                                    eop_seen_q <= 1'b1;
                                end else begin
                                    state_q <= LD_WRITE;
                                    we_q    <= 1'b1;
                                    wdata_q <= acc_q;
                                end
`else
                                if (acc_q == EOP_WORD) begin
                                    state_q      <= LD_DONE;
                                    prog_ready_q <= 1'b0;
                                    done_q       <= 1'b1;
                                    core_rst_q   <= 1'b0;
                                end else begin
                                    state_q <= LD_WRITE;
                                    we_q    <= 1'b1;
                                    wdata_q <= acc_q;
                                end
`endif
                            end
                        end else if (mem_ack_i) begin
                            // Address wraps naturally at 2^ADDR_W
                            state_q <= LD_LOAD;
                            we_q    <= 1'b0;
                            addr_q  <= addr_q + 1'b1;
`ifdef UART_LOADER_CKSUM_EN
                            cksum_q <= cksum_q + wdata_q;
`endif
                        end
                    end
                end
                LD_DONE: begin
                    state_q <= LD_DONE;
                end
                default: state_q <= LD_WAIT_EN;
            endcase
        end
    end

    assign prog_ready_o = prog_ready_q;
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign core_rst_o   = core_rst_q;
    assign done_o       = done_q;
    assign frame_err_o  = frame_err_q;
`ifdef UART_LOADER_CKSUM_EN
    assign cksum_err_o  = cksum_err_q;
`else
    assign cksum_err_o  = 1'b0;
`endif

endmodule
